// File: rtl/clmul_pkg.sv
// Shared types and helpers for the Zbc carry-less multiply controller.
//   clmul_op_t         : request op encoding (NONE is ignored by the controller)
//   clmul_ctrl_state_t : sequencer states
//   clmul_select       : picks the op-specific XLEN-wide half of a 2*XLEN product
package clmul_pkg;

  typedef enum logic [1:0] {
    CLMUL_NONE = 2'b00,
    CLMUL_LO   = 2'b01,
    CLMUL_R    = 2'b10,
    CLMUL_H    = 2'b11
  } clmul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } clmul_ctrl_state_t;

  // Widest operand the selector helper supports; callers zero-extend into it.
  localparam int unsigned CLMUL_XLEN_MAX = 64;

  // The product is passed zero-extended to 2*CLMUL_XLEN_MAX bits, so a right
  // shift by the op-dependent amount leaves the wanted half in the low bits.
  function automatic logic [CLMUL_XLEN_MAX-1:0] clmul_select(
    input clmul_op_t                     op,
    input logic [2*CLMUL_XLEN_MAX-1:0]   product,
    input int unsigned                   xlen
  );
    logic [2*CLMUL_XLEN_MAX-1:0] shifted;
    case (op)
      CLMUL_H: shifted = product >> xlen;
      CLMUL_R: shifted = product >> (xlen - 1);
      default: shifted = product;
    endcase
    return shifted[CLMUL_XLEN_MAX-1:0];
  endfunction

endpackage

// File: rtl/clmul_ctrl_result_sel.sv
// Combinational half-selector for carry-less multiply results.
//   op      : clmul_op_t encoding of the requested result
//   product : full 2*XLEN carry-less product
//   result  : XLEN-bit half chosen by op (LO / H / R)
module clmul_result_sel
  import clmul_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]        op,
  input  logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   result
);

  always_comb begin
    result = XLEN'(clmul_select(clmul_op_t'(op), (2*CLMUL_XLEN_MAX)'(product), XLEN));
  end

endmodule

// File: rtl/clmul_ctrl.sv
// Execute-stage sequencer for the Zbc carry-less multiply unit.
//   clk, resetn          : clock, asynchronous active-low reset
//   stall, flush         : pipeline freeze / abort of the in-flight request
//   req_valid/op/a/b     : decoded request from the pipeline
//   busy                 : hold request back to the pipeline
//   res_valid, res_data  : selected XLEN-bit result (valid in DONE only)
//   mul_start/a/b        : start pulse and operands to the iterative multiplier
//   mul_eoc, mul_res     : multiplier completion and 2*XLEN product
// A one-entry operand cache lets a clmul/clmulh/clmulr sequence on identical
// operands reuse the last product without re-running the multiplier.
module clmul_ctrl
  import clmul_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          USE_CACHE = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  input  logic              flush,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  output logic              busy,
  output logic              res_valid,
  output logic [XLEN-1:0]   res_data,
  output logic              mul_start,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  input  logic              mul_eoc,
  input  logic [2*XLEN-1:0] mul_res
);

  clmul_ctrl_state_t state_q, state_d;
  clmul_op_t         op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic              cache_valid_q, cache_valid_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   hold_q, hold_d;

  logic              req_legal;
  logic              accept;
  logic              hit;
  logic              capture;
  logic [XLEN-1:0]   sel_data;

  assign req_legal = req_valid && (req_op != CLMUL_NONE);
  assign accept    = (state_q == IDLE) && req_legal && !stall && !flush;
  assign hit       = USE_CACHE && cache_valid_q && (req_a == cache_a_q) && (req_b == cache_b_q);
  assign capture   = (state_q == RUN) && mul_eoc && !stall && !flush;

  clmul_result_sel #(.XLEN(XLEN)) u_result_sel (
    .op      (op_q),
    .product (prod_q),
    .result  (sel_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      op_q          <= CLMUL_NONE;
      a_q           <= '0;
      b_q           <= '0;
      cache_a_q     <= '0;
      cache_b_q     <= '0;
      cache_valid_q <= 1'b0;
      prod_q        <= '0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      cache_a_q     <= cache_a_d;
      cache_b_q     <= cache_b_d;
      cache_valid_q <= cache_valid_d;
      prod_q        <= prod_d;
      hold_q        <= hold_d;
    end
  end

  // Next state: flush overrides everything; completion comes only from mul_eoc.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = hit ? DONE : RUN;
        RUN:     if (mul_eoc && !stall) state_d = DONE;
        DONE:    if (!stall) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    cache_a_d     = cache_a_q;
    cache_b_d     = cache_b_q;
    cache_valid_d = cache_valid_q;
    prod_d        = prod_q;
    hold_d        = res_data;
    if (accept) begin
      op_d = clmul_op_t'(req_op);
      a_d  = req_a;
      b_d  = req_b;
    end
    if (capture) begin
      prod_d        = mul_res;
      cache_a_d     = a_q;
      cache_b_d     = b_q;
      cache_valid_d = 1'b1;
    end
  end

  // Outputs: result is only presented in DONE; elsewhere the last one is held.
  always_comb begin
    busy      = ((state_q == IDLE) && req_legal) || (state_q == RUN);
    mul_start = accept && !hit;
    mul_a     = (state_q == IDLE) ? req_a : a_q;
    mul_b     = (state_q == IDLE) ? req_b : b_q;
    res_valid = (state_q == DONE);
    res_data  = (state_q == DONE) ? sel_data : hold_q;
  end

endmodule

// File: tb/tb_clmul_ctrl.sv
module tb_clmul_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        busy, res_valid, mul_start, mul_eoc;
  logic [31:0] res_data, mul_a, mul_b;
  logic [63:0] mul_res;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clmul_ctrl #(.XLEN(32), .USE_CACHE(1'b1)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .busy(busy), .res_valid(res_valid), .res_data(res_data),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_eoc(mul_eoc), .mul_res(mul_res)
  );

  function automatic logic [63:0] clmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p = '0;
    for (int i = 0; i < 32; i++)
      if (b[i]) p = p ^ ({32'h0, a} << i);
    return p;
  endfunction

  function automatic logic [31:0] sel_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p = clmul_ref(a, b);
    logic [63:0] r;
    if (op == 2'b11)      r = p / 64'h1_0000_0000;
    else if (op == 2'b10) r = p / 64'h8000_0000;
    else                  r = p;
    return r[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Multiplier stand-in: 5 unstalled cycles from start to eoc, aborted by flush.
  int          mcnt;
  logic [63:0] mprod;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) mcnt <= 0;
    else if (flush) mcnt <= 0;
    else if (mul_start) begin
      mcnt  <= 5;
      mprod <= clmul_ref(mul_a, mul_b);
    end else if (mcnt > 0 && !stall) mcnt <= mcnt - 1;
  end
  assign mul_eoc = (mcnt == 1);
  assign mul_res = mul_eoc ? mprod : 64'hA5A5_5A5A_C3C3_3C3C;

  // Transaction-level model: remaining unstalled cycles of a run, a showing
  // flag for the result, and the last operand pair a finished run computed.
  int          m_wait;
  logic        m_show, m_cache_ok;
  logic [1:0]  m_op;
  logic [31:0] m_a, m_b, m_ca, m_cb, m_last;
  logic        m_hit;
  assign m_hit = m_cache_ok && (req_a == m_ca) && (req_b == m_cb);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_wait <= 0; m_show <= 1'b0; m_cache_ok <= 1'b0;
      m_op <= 2'b00; m_a <= '0; m_b <= '0; m_ca <= '0; m_cb <= '0; m_last <= '0;
    end else begin
      if (m_show) m_last <= sel_ref(m_op, m_a, m_b);
      if (flush) begin
        m_wait <= 0;
        m_show <= 1'b0;
      end else if (m_show) begin
        if (!stall) m_show <= 1'b0;
      end else if (m_wait > 0) begin
        if (!stall) begin
          m_wait <= m_wait - 1;
          if (m_wait == 1) begin
            m_show <= 1'b1; m_cache_ok <= 1'b1; m_ca <= m_a; m_cb <= m_b;
          end
        end
      end else if (req_valid && req_op != 2'b00 && !stall) begin
        m_op <= req_op; m_a <= req_a; m_b <= req_b;
        if (m_hit) m_show <= 1'b1;
        else       m_wait <= 5;
      end
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_mul_start", mul_start, 0);
    end else begin
      logic idle_req, exp_start;
      idle_req  = !m_show && (m_wait == 0) && req_valid && (req_op != 2'b00);
      exp_start = idle_req && !stall && !flush && !m_hit;
      chk("busy", busy, idle_req || (m_wait > 0));
      chk("mul_start", mul_start, exp_start);
      chk("res_valid", res_valid, m_show);
      chk("res_data", res_data, m_show ? sel_ref(m_op, m_a, m_b) : m_last);
      if (exp_start) begin
        chk("mul_a", mul_a, req_a);
        chk("mul_b", mul_b, req_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle (the acceptance cycle T); returns in T+1.
  task automatic send(input string name, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic exp_start);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    chk({name, "_start"}, mul_start, exp_start);
    chk({name, "_busy"}, busy, 1);
    tick();
    req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0;
  endtask

  // Counts cycles after acceptance until res_valid; returns at that negedge.
  task automatic wait_res(input string name, input logic [31:0] exp_d, input int exp_lat, input int start);
    int cnt = start;
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
      else cnt++;
    end
    chk({name, "_seen"}, seen, 1);
    chk({name, "_latency"}, cnt, exp_lat);
    chk({name, "_data"}, res_data, exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Basic run then cache hit on the same operands.
    send("lo3", 2'b01, 32'h3, 32'h3, 1'b1);
    wait_res("lo3", 32'h0000_0005, 6, 1);
    tick();
    send("h3", 2'b11, 32'h3, 32'h3, 1'b0);
    wait_res("h3", 32'h0000_0000, 1, 1);
    tick();

    // High / reversed halves on the top bit.
    send("h8", 2'b11, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_res("h8", 32'h4000_0000, 6, 1);
    tick();
    send("r8", 2'b10, 32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_res("r8", 32'h8000_0000, 1, 1);
    tick();

    // Three stall cycles mid-run, then stall while the result is shown.
    send("stl", 2'b01, 32'hFFFF_FFFF, 32'h2, 1'b1);
    tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    wait_res("stl", 32'hFFFF_FFFE, 9, 5);
    #1 stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      chk("stl_hold_valid", res_valid, 1);
      chk("stl_hold_data", res_data, 32'hFFFF_FFFE);
    end
    tick();
    stall = 1'b0;
    tick();
    send("stlh", 2'b11, 32'hFFFF_FFFF, 32'h2, 1'b0);
    wait_res("stlh", 32'h0000_0001, 1, 1);
    tick();

    // Flush one cycle after acceptance: no result, cache not filled.
    send("fl", 2'b01, 32'h1234_5678, 32'h9, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("fl_no_valid", res_valid, 0);
      chk("fl_not_busy", busy, 0);
      tick();
    end
    send("fl2", 2'b01, 32'h1234_5678, 32'h9, 1'b1);
    wait_res("fl2", 32'h8396_E5B8, 6, 1);
    tick();

    // Asynchronous reset mid-run clears the cache.
    send("rr", 2'b01, 32'h3, 32'h5, 1'b1);
    tick();
    #2 resetn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_res_data", res_data, 0);
    chk("arst_mul_start", mul_start, 0);
    tick();
    resetn = 1'b1;
    send("post_rst", 2'b01, 32'h1234_5678, 32'h9, 1'b1);
    wait_res("post_rst", 32'h8396_E5B8, 6, 1);
    tick();

    // Illegal op is ignored; controller stays idle and then takes a hit.
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'h1234_5678; req_b = 32'h9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("op0_busy", busy, 0);
      chk("op0_start", mul_start, 0);
      tick();
    end
    req_valid = 1'b0;
    send("op0_h", 2'b11, 32'h1234_5678, 32'h9, 1'b0);
    wait_res("op0_h", 32'h0000_0000, 1, 1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clmul_ctrl.md
Name: clmul_ctrl

Overview:
Execute-stage sequencer for the Zbc carry-less multiply unit (clmul/clmulh/clmulr).
- Accepts decoded requests from the pipeline and pulses start to the iterative multiplier.
- Waits for its end-of-conversion, captures the 64-bit product and returns the 32-bit half selected by the op.
- Holds a one-entry product cache, so a clmul/clmulh/clmulr pair on identical operands completes without re-running the multiplier.

Parameters:
XLEN, 32, operand/result width; product is 2*XLEN.
USE_CACHE, 1, 1 = enable operand-reuse cache; 0 = every request runs the multiplier.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
stall  in  1  pipeline stall; freezes controller state (also routed to the multiplier)
flush  in  1  abort in-flight request
req_valid  in  1  request present this cycle
req_op  in  2  clmul_op_t: 01 CLMUL (low), 10 CLMULR, 11 CLMULH; 00 illegal/ignored
req_a  in  XLEN  rs1 value
req_b  in  XLEN  rs2 value
busy  out  1  hold request to the pipeline
res_valid  out  1  result valid
res_data  out  XLEN  selected result
mul_start  out  1  start pulse to the multiplier
mul_a  out  XLEN  multiplier operand A
mul_b  out  XLEN  multiplier operand B
mul_eoc  in  1  multiplier end-of-conversion
mul_res  in  2*XLEN  multiplier product; valid in the cycle mul_eoc is high after a start

Behaviour:
- Reset (async, resetn=0): state=IDLE, cache_valid=0, all captured registers 0; busy=0, res_valid=0, res_data=0, mul_start=0.
- States: IDLE, RUN, DONE.
- IDLE, req_valid=1, op!=00, stall=0, flush=0:
  - latch op, a, b.
  - hit = USE_CACHE && cache_valid && a==cache_a && b==cache_b.
  - hit: go to DONE directly; no mul_start.
  - miss: mul_start=1 (combinational, this cycle only), mul_a/mul_b driven from req_a/req_b this cycle; go to RUN.
- IDLE, op==00 or stall=1: no action.
- busy = (IDLE && req_valid && op!=00) || RUN. busy is 0 in DONE.
- RUN:
  - mul_a/mul_b hold the latched operands.
  - mul_eoc=1 && stall=0: product <= mul_res, cache_a/cache_b <= latched operands, cache_valid <= 1; go to DONE.
  - mul_eoc sampled during stall is ignored.
- DONE: res_valid=1 with res_data selected from the product register:
  - CLMUL = P[XLEN-1:0]
  - CLMULH = P[2XLEN-1:XLEN]
  - CLMULR = P[2XLEN-2:XLEN-1]
  - stall=0: go to IDLE. stall=1: remain in DONE, output stable.
- Outside DONE: res_valid=0, res_data holds its last value.
- Flush (highest priority after reset):
  - any state goes to IDLE next cycle; no res_valid.
  - flush during RUN leaves the cache unchanged (the product is not captured).
  - flush in the same cycle as an IDLE request: the request is not accepted, mul_start=0.
- Request back-to-back: a new request is accepted only from IDLE, so the minimum spacing is one DONE cycle.
- Latency, no stalls, 8-bit/cycle multiplier: acceptance at cycle T, mul_eoc at T+5, res_valid at T+6. Cache hit: res_valid at T+1.
- The controller never counts iterations; completion is taken only from mul_eoc.
- The cache is never invalidated except by reset. Operand equality alone defines a hit.

Decomposition:
- Package clmul_pkg:
  - clmul_op_t enum (NONE=00, LO=01, R=10, H=11)
  - clmul_ctrl_state_t enum (IDLE, RUN, DONE)
  - function clmul_select(op, product) returning XLEN bits
- Sub-module clmul_result_sel: combinational half-selector wrapping clmul_select. It is reused by the bypass path.
- The multiplier is instantiated beside the controller, not inside it.

Test Plan:
- CLMUL, a=0x00000003, b=0x00000003, no stall -> mul_start pulse at T, res_valid at T+6, res_data=0x00000005; CLMULH on the same operands issued next -> res_data=0x00000000 at accept+1, no mul_start.
- CLMULH then CLMULR, a=b=0x80000000 -> CLMULH=0x40000000 (full run); CLMULR=0x80000000 via cache hit one cycle after acceptance.
- Stall: stall=1 for 3 cycles mid-RUN with a=0xFFFFFFFF, b=0x00000002 -> res_valid delayed by exactly 3 cycles; CLMUL result=0xFFFFFFFE, CLMULH=0x00000001; stall in DONE holds res_valid and data.
- Flush: flush one cycle after acceptance -> IDLE next cycle, no res_valid; repeating the same request gives a cache miss (new mul_start).
- Async reset mid-RUN -> all outputs 0 immediately; following request is a miss even with previously cached operands.
- req_op=00 with req_valid=1 -> busy=0, no mul_start, state stays IDLE.
